fu_ready_tracker: RTL and testbench

FU_READY_TRACKER -- requirements
Module: fu_ready_tracker

---
 rtl/fu_ready_tracker.sv | 119 +++++++++++
 tb/tb_fu_ready_tracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_ready_tracker.sv
// Functional-unit ready tracker: nine ALU busy counters (SIMD0-3, SIMF0-3,
// SALU) plus an LSU credit counter and a sticky issue-error flag.

// Per-ALU busy counter. Ready is decoded purely from the registered count.
module fu_busy_lane #(
  parameter int BUSY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sel_i,
  input  logic flush_i,
  output logic ready_o,
  output logic rej_o
);
  logic [3:0] cnt_q, cnt_d;

  assign ready_o = (cnt_q == 4'd0);
  // A select to a busy unit is an error unless flush drops it anyway.
  assign rej_o   = sel_i & ~flush_i & ~ready_o;

  // Next count: flush clears, accepted select loads, otherwise count down to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)               cnt_d = 4'd0;
    else if (sel_i && ready_o) cnt_d = 4'(BUSY);
    else if (cnt_q != 4'd0)    cnt_d = cnt_q - 4'd1;
  end

  // Busy count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
  end
endmodule

module fu_ready_tracker #(
  parameter int SIMD_BUSY_CYCLES = 4,
  parameter int SIMF_BUSY_CYCLES = 4,
  parameter int SALU_BUSY_CYCLES = 1,
  parameter int LSU_CREDITS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] simd_alu_select,
  input  logic [3:0] simf_alu_select,
  input  logic       lsu_select,
  input  logic       salu_select,
  input  logic       lsu_done,
  input  logic       fu_flush,
  output logic [3:0] simd_alu_ready,
  output logic [3:0] simf_alu_ready,
  output logic       lsu_ready,
  output logic       salu_alu_ready,
  output logic [2:0] lsu_outstanding,
  output logic       issue_err
);
  localparam int       NUM_LANES = 9;
  localparam bit [2:0] CRED      = 3'(LSU_CREDITS);

  logic [NUM_LANES-1:0] alu_sel, alu_ready, alu_rej;
  logic [2:0]           lsu_cnt_q, lsu_cnt_d;
  logic                 issue_err_q, err_set;
  logic                 lsu_acc, done_acc, multi_sel;
  logic [9:0]           cnt_sel;

  // Lane order: SIMD0-3, SIMF0-3, SALU.
  assign alu_sel = {salu_select, simf_alu_select, simd_alu_select};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    localparam int B = (g < 4) ? SIMD_BUSY_CYCLES :
                       (g < 8) ? SIMF_BUSY_CYCLES : SALU_BUSY_CYCLES;
    fu_busy_lane #(.BUSY(B)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .sel_i   (alu_sel[g]),
      .flush_i (fu_flush),
      .ready_o (alu_ready[g]),
      .rej_o   (alu_rej[g])
    );
  end

  assign simd_alu_ready  = alu_ready[3:0];
  assign simf_alu_ready  = alu_ready[7:4];
  assign salu_alu_ready  = alu_ready[8];
  assign lsu_ready       = (lsu_cnt_q < CRED);
  assign lsu_outstanding = lsu_cnt_q;
  assign issue_err       = issue_err_q;

  assign lsu_acc  = lsu_select & lsu_ready;
  assign done_acc = lsu_done & (lsu_cnt_q != 3'd0);

  // Selects dropped by a flush do not count toward the multi-select check.
  assign cnt_sel   = {lsu_select, fu_flush ? {NUM_LANES{1'b0}} : alu_sel};
  assign multi_sel = |(cnt_sel & (cnt_sel - 10'd1));

  assign err_set = (|alu_rej) | (lsu_select & ~lsu_ready)
                 | (lsu_done & (lsu_cnt_q == 3'd0)) | multi_sel;

  // LSU credit next-state: accepted issue and accepted retire cancel out.
  always_comb begin
    lsu_cnt_d = lsu_cnt_q;
    case ({lsu_acc, done_acc})
      2'b10:   lsu_cnt_d = lsu_cnt_q + 3'd1;
      2'b01:   lsu_cnt_d = lsu_cnt_q - 3'd1;
      default: lsu_cnt_d = lsu_cnt_q;
    endcase
  end

  // LSU credit count and sticky error flag; flush touches neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_cnt_q   <= 3'd0;
      issue_err_q <= 1'b0;
    end else begin
      lsu_cnt_q <= lsu_cnt_d;
      if (err_set) issue_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fu_ready_tracker.sv
// Bench for fu_ready_tracker: directed scenarios plus a randomized run,
// all compared against an array-based reference model.
module tb_fu_ready_tracker;
  localparam int SIMD_B = 4, SIMF_B = 4, SALU_B = 1, CRED = 4;

  logic       clk = 1'b0, rst;
  logic [3:0] simd_sel, simf_sel;
  logic       lsu_sel, salu_sel, lsu_done, fu_flush;
  logic [3:0] simd_rdy, simf_rdy;
  logic       lsu_rdy, salu_rdy, err;
  logic [2:0] lsu_out;

  int checks = 0, errors = 0;
  int m_busy[9];
  int m_lsu;
  bit m_err;

  fu_ready_tracker dut (
    .clk(clk), .rst(rst),
    .simd_alu_select(simd_sel), .simf_alu_select(simf_sel),
    .lsu_select(lsu_sel), .salu_select(salu_sel),
    .lsu_done(lsu_done), .fu_flush(fu_flush),
    .simd_alu_ready(simd_rdy), .simf_alu_ready(simf_rdy),
    .lsu_ready(lsu_rdy), .salu_alu_ready(salu_rdy),
    .lsu_outstanding(lsu_out), .issue_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int busy_of(input int i);
    return (i < 4) ? SIMD_B : (i < 8) ? SIMF_B : SALU_B;
  endfunction

  function automatic bit sel_of(input int i);
    return (i < 4) ? simd_sel[i] : (i < 8) ? simf_sel[i-4] : salu_sel;
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 0;
    m_lsu = 0;
    m_err = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int n;
    n = lsu_sel;
    if (!fu_flush) for (int i = 0; i < 9; i++) n += sel_of(i);
    if (n > 1) m_err = 1;
    for (int i = 0; i < 9; i++) begin
      if (fu_flush) m_busy[i] = 0;
      else if (sel_of(i) && m_busy[i] == 0) m_busy[i] = busy_of(i);
      else begin
        if (sel_of(i)) m_err = 1;
        if (m_busy[i] > 0) m_busy[i]--;
      end
    end
    begin
      bit as, ad;
      as = lsu_sel && (m_lsu < CRED);
      ad = lsu_done && (m_lsu > 0);
      if (lsu_sel && !as) m_err = 1;
      if (lsu_done && !ad) m_err = 1;
      m_lsu = m_lsu + int'(as) - int'(ad);
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [3:0] es, ef;
    for (int i = 0; i < 4; i++) begin
      es[i] = (m_busy[i] == 0);
      ef[i] = (m_busy[i+4] == 0);
    end
    chk({tag, ".simd_rdy"}, simd_rdy, es);
    chk({tag, ".simf_rdy"}, simf_rdy, ef);
    chk({tag, ".salu_rdy"}, salu_rdy, m_busy[8] == 0);
    chk({tag, ".lsu_out"},  lsu_out,  m_lsu);
    chk({tag, ".lsu_rdy"},  lsu_rdy,  m_lsu < CRED);
    chk({tag, ".err"},      err,      m_err);
  endtask

  task automatic drive(input logic [3:0] sd, input logic [3:0] sf, input logic ls,
                       input logic sa, input logic dn, input logic fl);
    simd_sel = sd; simf_sel = sf; lsu_sel = ls; salu_sel = sa; lsu_done = dn; fu_flush = fl;
  endtask

  task automatic idle();
    drive(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One clock: model steps on the driven inputs, DUT sampled 1 time unit after the edge.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    cmp_model(tag);
    idle();
  endtask

  // Assert reset mid-cycle, check immediately, release before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    cmp_model(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    #12;
    chk("rst.simd_rdy", simd_rdy, 4'hF);
    chk("rst.simf_rdy", simf_rdy, 4'hF);
    chk("rst.salu_rdy", salu_rdy, 1'b1);
    chk("rst.lsu_rdy",  lsu_rdy,  1'b1);
    chk("rst.lsu_out",  lsu_out,  3'd0);
    chk("rst.err",      err,      1'b0);
    @(negedge clk);
    rst = 1'b1;

    // SIMD1 busy for exactly four cycles
    drive(4'b0010, 4'h0, 0, 0, 0, 0);
    cyc("simd1");
    chk("simd1.t1", simd_rdy, 4'b1101);
    for (int k = 2; k <= 4; k++) begin
      cyc("simd1");
      chk("simd1.busy", simd_rdy, 4'b1101);
    end
    cyc("simd1");
    chk("simd1.t5", simd_rdy, 4'hF);
    chk("simd1.others", {simf_rdy, salu_rdy}, 5'h1F);

    // LSU credits exhausted, fifth select rejected
    for (int k = 0; k < 4; k++) begin
      drive(4'h0, 4'h0, 1, 0, 0, 0);
      cyc("lsu_fill");
    end
    chk("lsu_full.out", lsu_out, 3'd4);
    chk("lsu_full.rdy", lsu_rdy, 1'b0);
    chk("lsu_full.err0", err, 1'b0);
    drive(4'h0, 4'h0, 1, 0, 0, 0);
    cyc("lsu_over");
    chk("lsu_over.out", lsu_out, 3'd4);
    chk("lsu_over.err", err, 1'b1);
    do_reset("rst1");

    // select+done cancel, then underflow
    for (int k = 0; k < 2; k++) begin
      drive(4'h0, 4'h0, 1, 0, 0, 0);
      cyc("lsu2");
    end
    drive(4'h0, 4'h0, 1, 0, 1, 0);
    cyc("lsu_both");
    chk("lsu_both.out", lsu_out, 3'd2);
    chk("lsu_both.err", err, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(4'h0, 4'h0, 0, 0, 1, 0);
      cyc("lsu_drain");
    end
    drive(4'h0, 4'h0, 0, 0, 1, 0);
    cyc("lsu_under");
    chk("lsu_under.out", lsu_out, 3'd0);
    chk("lsu_under.err", err, 1'b1);
    do_reset("rst2");

    // flush beats a same-cycle select, no error
    drive(4'h0, 4'b0100, 0, 0, 0, 0);
    cyc("simf2");
    cyc("simf2");
    drive(4'h0, 4'b0001, 0, 0, 0, 1);
    cyc("flush");
    chk("flush.rdy", {simd_rdy, simf_rdy, salu_rdy}, 9'h1FF);
    chk("flush.err", err, 1'b0);
    cyc("flush.after");
    chk("flush.simf0", simf_rdy, 4'hF);

    // two selects in one cycle: both accepted, error flagged
    drive(4'h0, 4'h0, 1, 1, 0, 0);
    cyc("dual");
    chk("dual.salu", salu_rdy, 1'b0);
    chk("dual.lsu", lsu_out, 3'd1);
    chk("dual.err", err, 1'b1);
    do_reset("rst3");

    // asynchronous reset mid-cycle while busy with credits outstanding
    for (int k = 0; k < 3; k++) begin
      drive(4'h0, 4'h0, 1, 0, 0, 0);
      cyc("pre_rst");
    end
    drive(4'b0001, 4'h0, 0, 0, 0, 0);
    cyc("pre_rst");
    chk("pre_rst.out", lsu_out, 3'd3);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async.rdy", {simd_rdy, simf_rdy, salu_rdy, lsu_rdy}, 10'h3FF);
    chk("async.out", lsu_out, 3'd0);
    chk("async.err", err, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] sd, sf;
      for (int b = 0; b < 4; b++) begin
        sd[b] = ($urandom_range(7) == 0);
        sf[b] = ($urandom_range(7) == 0);
      end
      drive(sd, sf, $urandom_range(3) == 0, $urandom_range(7) == 0,
            $urandom_range(2) == 0, $urandom_range(15) == 0);
      cyc("rand");
      if ($urandom_range(199) == 0) do_reset("rand_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
